// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard scoreboard with redirect flush sequencing and a saturating
// stall counter; pipeline enables are decoded combinationally from state and ID.
module hazard_scoreboard_unit #(
    parameter int LOAD_LAT     = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_is_load,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              mem_ready,
    input  logic              pcSrc,
    output logic              pcWrite,
    output logic              ifIdWrite,
    output logic              selectNOP,
    output logic              IFflush,
    output logic [PERF_W-1:0] stall_cycles
);

    logic [2:0]        r_cnt [1:31];
    logic [1:0]        r_flush_cnt;
    logic [PERF_W-1:0] r_stall_cycles;

    logic w_rs1_busy;
    logic w_rs2_busy;
    logic w_hazard;
    logic w_flushing;
    logic w_advance;
    logic w_load_en;

    // x0 has no entry, so a zero source index never matches and never hazards
    always_comb begin
        w_rs1_busy = 1'b0;
        w_rs2_busy = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if (rs1_id == 5'(i) && r_cnt[i] != 3'd0) w_rs1_busy = 1'b1;
            if (rs2_id == 5'(i) && r_cnt[i] != 3'd0) w_rs2_busy = 1'b1;
        end
    end

    assign w_hazard   = issue_valid && ((rs1_used && w_rs1_busy) || (rs2_used && w_rs2_busy));
    assign w_flushing = pcSrc || (r_flush_cnt != 2'd0);
    assign w_advance  = mem_ready && !w_hazard && !w_flushing;
    assign w_load_en  = w_advance && issue_valid && issue_is_load && (issue_rd != 5'd0);

    always_comb begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        selectNOP = 1'b0;
        IFflush   = 1'b0;
        if (!rst) begin
            if (!mem_ready) begin
                pcWrite   = 1'b0;
                ifIdWrite = 1'b0;
            end else if (w_flushing) begin
                selectNOP = 1'b1;
                IFflush   = 1'b1;
            end else if (w_hazard) begin
                pcWrite   = 1'b0;
                ifIdWrite = 1'b0;
                selectNOP = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) r_cnt[i] <= 3'd0;
            r_flush_cnt    <= 2'd0;
            r_stall_cycles <= '0;
        end else if (mem_ready) begin
            // a fresh load on an entry overrides its decrement this edge
            for (int i = 1; i < 32; i++) begin
                if (w_load_en && issue_rd == 5'(i))
                    r_cnt[i] <= 3'(LOAD_LAT);
                else if (r_cnt[i] != 3'd0)
                    r_cnt[i] <= r_cnt[i] - 3'd1;
            end
            if (pcSrc)
                r_flush_cnt <= 2'(FLUSH_CYCLES - 1);
            else if (r_flush_cnt != 2'd0)
                r_flush_cnt <= r_flush_cnt - 2'd1;
            if (w_hazard && !w_flushing && !(&r_stall_cycles))
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 2, meaning cycles after a load leaves ID before its rd is forwardable; legal range 1-7.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, meaning cycles IFflush is held after a redirect; legal range 1-4.
REQ-003 SHALL have parameter PERF_W, default 32, meaning stall-counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port issue_valid  input  1  an instruction occupies ID this cycle.
REQ-007 SHALL have port issue_is_load  input  1  the ID instruction is a load (memRead).
REQ-008 SHALL have port issue_rd  input  5  destination register of the ID instruction.
REQ-009 SHALL have ports rs1_id, rs2_id  input  5 each  source registers of the ID instruction.
REQ-010 SHALL have ports rs1_used, rs2_used  input  1 each  the corresponding source is read.
REQ-011 SHALL have port mem_ready  input  1  data memory is ready; low freezes the pipeline.
REQ-012 SHALL have port pcSrc  input  1  taken branch/jump redirect resolved this cycle.
REQ-013 SHALL have port pcWrite  output  1  PC update enable, active-high.
REQ-014 SHALL have port ifIdWrite  output  1  IF/ID register write enable, active-high.
REQ-015 SHALL have port selectNOP  output  1  insert bubble into ID/EX.
REQ-016 SHALL have port IFflush  output  1  clear IF/ID contents.
REQ-017 SHALL have port stall_cycles  output  PERF_W  saturating count of load-use stall cycles.

Function
REQ-018 SHALL keep a scoreboard of 31 counters (x1-x31), each 3 bits; x0 has no entry and never hazards.
REQ-019 SHALL define hazard = issue_valid and ((rs1_used and rs1_id!=0 and cnt[rs1_id]!=0) or (rs2_used and rs2_id!=0 and cnt[rs2_id]!=0)), combinationally.
REQ-020 SHALL define advance = mem_ready and not hazard and not flushing, where flushing = pcSrc or flush_cnt!=0.
REQ-021 SHALL, when advance and issue_valid and issue_is_load and issue_rd!=0, load cnt[issue_rd] with LOAD_LAT on the next edge (overrides decrement of that entry).
REQ-022 SHALL, on every edge with mem_ready=1, decrement every nonzero counter not being loaded per REQ-021; counters never wrap below 0.
REQ-023 SHALL, when mem_ready=0, hold all counters, flush_cnt and stall_cycles, and drive pcWrite=0, ifIdWrite=0, selectNOP=0, IFflush=0.
REQ-024 SHALL, when mem_ready=1 and hazard and not flushing, drive pcWrite=0, ifIdWrite=0, selectNOP=1, IFflush=0 and increment stall_cycles, saturating at all-ones.
REQ-025 SHALL, when pcSrc=1 and mem_ready=1, load flush_cnt with FLUSH_CYCLES-1, drive IFflush=1, selectNOP=1, pcWrite=1, ifIdWrite=1; redirect has priority over hazard, and the ID instruction is not recorded in the scoreboard.
REQ-026 SHALL, while flush_cnt!=0 and mem_ready=1, drive IFflush=1, selectNOP=1, pcWrite=1, ifIdWrite=1 and decrement flush_cnt; a new pcSrc reloads it.
REQ-027 SHALL otherwise drive pcWrite=1, ifIdWrite=1, selectNOP=0, IFflush=0.
REQ-028 SHALL not create a hazard from an ID instruction on its own rd (no self-dependence in the same cycle).

Reset
REQ-029 SHALL, when rst=1 at an edge, clear all scoreboard counters, flush_cnt and stall_cycles to 0, regardless of mem_ready or pcSrc.
REQ-030 SHALL, during a rst=1 cycle, drive outputs per REQ-027 combinationally from the cleared state, with stall_cycles observed as 0 from the cycle after reset.

Verification
REQ-031 SHALL verify load-use: LOAD_LAT=2, load x5 issued, next ID reads rs1=x5 -> selectNOP=1, pcWrite=0 for 2 cycles, then advance; stall_cycles=2.
REQ-032 SHALL verify x0 and unused sources: load x0 then rs1=x0, or load x5 then rs2_id=x5 with rs2_used=0 -> no stall.
REQ-033 SHALL verify memory freeze: stall pending with cnt[x5]=1, mem_ready=0 for 3 cycles -> all enables 0, counter still 1, stall_cycles unchanged; resumes 1 stall cycle after mem_ready=1.
REQ-034 SHALL verify redirect priority: pcSrc=1 while hazard -> IFflush=1, selectNOP=1, pcWrite=1; with FLUSH_CYCLES=3, IFflush high for exactly 3 cycles.
REQ-035 SHALL verify reset mid-operation: rst=1 with cnt[x7]=2 and flush_cnt=1 -> next cycle rs1=x7 issues without stall, IFflush=0, stall_cycles=0.
REQ-036 SHALL verify saturation: PERF_W=4, 20 consecutive hazard cycles -> stall_cycles holds at 15.
